mux_nch_reg: RTL

- Parametrised N-channel, W-bit registered multiplexer.
- Generalises the 1-bit 2:1 structural mux.
- Two selection modes:
  - fixed select, driven by the `sel` port;
  - round-robin among requesting channels.
- Per-channel valid/ready handshake in, one registered valid/ready stream out.
- Used as the datapath source selector for the register-file write port and the bus-master front end.

---
 rtl/mux_nch_reg_pkg.sv | 16 +
 rtl/mux_nch_reg_rr_arbiter.sv | 32 +++
 rtl/mux_nch_reg.sv | 109 ++++++++++
 3 files changed

// File: rtl/mux_nch_reg_pkg.sv
// Shared definitions for the N-channel registered multiplexer: mode encodings
// and the wrapping channel-index increment used by the round-robin search.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Wraps explicitly at n-1 so non-power-of-two channel counts stay in range.
    function automatic int unsigned mod_inc(input int unsigned idx, input int unsigned n);
        if (idx >= n - 32'd1) begin
            return 32'd0;
        end
        return idx + 32'd1;
    endfunction

endpackage

// File: rtl/mux_nch_reg_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... (mod NCH) and
// grants the first requesting channel.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_valid,
    output logic [SELW-1:0] gnt_idx
);

    localparam int unsigned NCH_U = NCH;

    logic [SELW-1:0] cur;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cur       = ptr;
        for (int k = 0; k < NCH; k++) begin
            cur = SELW'(mod_inc(32'(cur), NCH_U));
            if (!gnt_valid && req[cur]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cur;
            end
        end
    end

endmodule

// File: rtl/mux_nch_reg.sv
// N-channel, W-bit registered multiplexer with fixed-select or round-robin
// grant, per-channel valid/ready inputs and a single registered output stage.
module mux_nch_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int NCH   = 4,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    // Handshake: a channel transfers when in_valid[g] && in_ready[g]; the
    // output item is consumed when out_valid && out_ready. in_ready is one-hot
    // or zero and only rises when the output register can be loaded.

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic             run_q;

    logic             rr_gnt_valid;
    logic [SELW-1:0]  rr_gnt_idx;
    logic             fix_gnt_valid;
    logic             gnt_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             load_en;
    logic             accept;
    logic [WIDTH-1:0] gnt_data;

    rr_arbiter #(
        .NCH (NCH)
    ) u_rr_arbiter (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_valid (rr_gnt_valid),
        .gnt_idx   (rr_gnt_idx)
    );

    // Out-of-range sel simply yields no grant.
    assign fix_gnt_valid = (int'(sel) < NCH) && in_valid[sel];

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        if (mode == MODE_RR) begin
            gnt_valid = rr_gnt_valid;
            gnt_idx   = rr_gnt_idx;
        end else begin
            gnt_valid = fix_gnt_valid;
            gnt_idx   = sel;
        end
    end

    // run_q holds off in_ready until the first clock edge after reset release.
    assign load_en  = !out_valid_q || out_ready;
    assign accept   = run_q && load_en && gnt_valid;
    assign in_ready = accept ? (NCH'(1) << gnt_idx) : '0;
    assign gnt_data = in_data[gnt_idx*WIDTH +: WIDTH];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= SELW'(NCH - 1);
            run_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            run_q       <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule
